// File: rtl/bsg_dlatch_pipe_if.sv
// Handshake bundle for bsg_dlatch_pipe: producer side, consumer side, gate and occupancy.
// The slave modport is the pipe itself; the master modport is whatever drives and drains it.
interface bsg_dlatch_pipe_if #(
  parameter int width_p  = 16,
  parameter int stages_p = 2
);
  localparam int count_width_lp = $clog2(stages_p + 1);

  logic                      en_i;
  logic [width_p-1:0]        data_i;
  logic                      v_i;
  logic                      ready_o;
  logic [width_p-1:0]        data_o;
  logic                      v_o;
  logic                      ready_i;
  logic [count_width_lp-1:0] count_o;

  modport master (
    output en_i, data_i, v_i, ready_i,
    input  ready_o, data_o, v_o, count_o
  );

  modport slave (
    input  en_i, data_i, v_i, ready_i,
    output ready_o, data_o, v_o, count_o
  );
endinterface

// File: rtl/bsg_dlatch_pipe.sv
// Gated elastic capture pipeline: stages_p flop stages with valid/ready flow, frozen while en_i=0.
// Optional macro BSG_DLATCH_PIPE_BYPASS_EN adds a same-cycle path through an empty pipe.
module bsg_dlatch_pipe #(
  parameter int width_p  = 16,
  parameter int stages_p = 2
) (
  input logic            clk_i,
  input logic            reset_n_i,
  bsg_dlatch_pipe_if.slave io
);
  localparam int count_width_lp = $clog2(stages_p + 1);
  localparam int last_lp        = stages_p - 1;

  logic [stages_p-1:0]       valid_r;
  logic [width_p-1:0]        data_r [stages_p];
  logic [count_width_lp-1:0] count_r;

  logic [stages_p-1:0] load;
  logic                pop;
  logic                push;
  logic                stored_push;
  logic                bypass;

  always_comb begin
    bypass = 1'b0;
`ifdef BSG_DLATCH_PIPE_BYPASS_EN
    bypass = (count_r == '0) & io.en_i & io.v_i & io.ready_i;
`endif
  end

  assign pop = io.en_i & valid_r[last_lp] & io.ready_i;

  // A stage may load when it is empty or its contents move on; walk from the output backwards.
  always_comb begin : load_chain
    logic chain;
    load  = '0;
    chain = pop;
    for (int k = stages_p - 1; k >= 0; k--) begin
      load[k] = io.en_i & (~valid_r[k] | chain);
      chain   = load[k];
    end
  end

  assign push        = io.v_i & load[0];
  assign stored_push = push & ~bypass;

  assign io.ready_o = load[0];
  assign io.v_o     = valid_r[last_lp] | bypass;
  assign io.data_o  = bypass ? io.data_i : data_r[last_lp];
  assign io.count_o = count_r;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      valid_r <= '0;
      count_r <= '0;
      for (int k = 0; k < stages_p; k++) begin
        data_r[k] <= '0;
      end
    end else begin
      if (load[0]) begin
        valid_r[0] <= stored_push;
        if (stored_push) begin
          data_r[0] <= io.data_i;
        end
      end
      // Data only moves with a valid source so empty slots never pick up garbage.
      for (int k = 1; k < stages_p; k++) begin
        if (load[k]) begin
          valid_r[k] <= valid_r[k-1];
          if (valid_r[k-1]) begin
            data_r[k] <= data_r[k-1];
          end
        end
      end
      if (stored_push & ~pop) begin
        count_r <= count_r + count_width_lp'(1);
      end else if (~stored_push & pop) begin
        count_r <= count_r - count_width_lp'(1);
      end
    end
  end

`ifndef SYNTHESIS
  hold_valid_when_gated: assert property (
    @(posedge clk_i) (reset_n_i && !io.en_i && valid_r[last_lp]) |=> valid_r[last_lp]
  );
`endif

endmodule

// File: tb/tb_bsg_dlatch_pipe.sv
// Scoreboard bench for bsg_dlatch_pipe: directed scenarios then random traffic against an
// item-age queue model (an item is visible once it has seen stages_p enabled edges and heads the queue).
module tb_bsg_dlatch_pipe;
  localparam int W  = 16;
  localparam int S  = 2;
`ifdef BSG_DLATCH_PIPE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bsg_dlatch_pipe_if #(.width_p(W), .stages_p(S)) bus ();

  bsg_dlatch_pipe #(.width_p(W), .stages_p(S)) dut (
    .clk_i    (clk),
    .reset_n_i(rst_n),
    .io       (bus.slave)
  );

  typedef struct {
    logic [W-1:0] data;
    int           age;
  } ent_t;

  ent_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   chk_en   = 1'b0;
  bit   byp_cycle = 1'b0;
  bit   clean    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model clock edge: reset empties the pipe, every enabled edge ages every item.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        q.delete();
        chk_en = 1'b1;
        clean  = 1'b1;
      end else if (bus.en_i) begin
        foreach (q[i]) q[i].age++;
      end
    end
  end

  // Monitor: compares DUT outputs to the model mid-cycle and retires popped items.
  int m_sz;
  bit m_vreg, m_byp, m_vexp, m_pop, m_rdy;
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        m_sz   = q.size();
        m_vreg = (m_sz > 0) && (q[0].age >= S);
        m_byp  = BYP && (m_sz == 0) && bus.en_i && bus.v_i && bus.ready_i;
        m_vexp = m_vreg || m_byp;
        m_pop  = bus.en_i && m_vreg && bus.ready_i;
        m_rdy  = bus.en_i && ((m_sz < S) || m_pop);
        byp_cycle = m_byp;
        chk("v_o", 32'(bus.v_o), 32'(m_vexp));
        chk("ready_o", 32'(bus.ready_o), 32'(m_rdy));
        chk("count_o", 32'(bus.count_o), m_sz);
        if (m_vexp) begin
          chk("data_o", 32'(bus.data_o), m_byp ? 32'(bus.data_i) : 32'(q[0].data));
        end else if (clean) begin
          chk("data_o_clear", 32'(bus.data_o), 32'd0);
        end
        if (m_pop && rst_n) void'(q.pop_front());
      end
    end
  end

  // Stimulus: drive one cycle, then record the item if the model says the pipe took it.
  task automatic step(input logic rn, input logic e, input logic v,
                      input logic [W-1:0] d, input logic r);
    @(posedge clk);
    #1;
    rst_n       = rn;
    bus.en_i    = e;
    bus.v_i     = v;
    bus.data_i  = d;
    bus.ready_i = r;
    @(negedge clk);
    #2;
    if (rn && e && v && (q.size() < S) && !byp_cycle) begin
      q.push_back('{data: d, age: 0});
      clean = 1'b0;
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.en_i    = 1'b1;
    bus.v_i     = 1'b1;
    bus.data_i  = 16'hBEEF;
    bus.ready_i = 1'b1;

    step(1'b0, 1'b1, 1'b1, 16'hBEEF, 1'b1);
    step(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);

    for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, 1'b1, 16'(i), 1'b1);
    repeat (3) step(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);

    step(1'b1, 1'b1, 1'b1, 16'hA5A5, 1'b0);
    step(1'b1, 1'b1, 1'b1, 16'h5A5A, 1'b0);
    step(1'b1, 1'b1, 1'b1, 16'hDEAD, 1'b0);
    step(1'b1, 1'b1, 1'b1, 16'h1234, 1'b1);
    repeat (3) step(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);

    step(1'b1, 1'b1, 1'b1, 16'hCAFE, 1'b0);
    repeat (2) step(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
    repeat (5) step(1'b1, 1'b0, 1'b1, 16'($urandom), 1'b1);
    repeat (2) step(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);

    step(1'b1, 1'b1, 1'b1, 16'h1111, 1'b0);
    step(1'b1, 1'b1, 1'b1, 16'h2222, 1'b0);
    step(1'b1, 1'b1, 1'b1, 16'h2323, 1'b0);
    step(1'b0, 1'b1, 1'b1, 16'h3333, 1'b1);
    repeat (3) step(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);

    step(1'b1, 1'b1, 1'b1, 16'h7777, 1'b1);
    repeat (3) step(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);

    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 63) != 0),
           ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 3) != 0),
           16'($urandom),
           ($urandom_range(0, 3) != 0));
    end

    repeat (S + 3) step(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
